// File: rtl/fma_write_buffer.sv
// rtl/fma_write_buffer.sv - packs three FMA result vectors per abc line and queues lines for the memory block
// Show-ahead line FIFO with a registered head so the output holds its last value once drained.
module fma_write_buffer #(
   parameter int FMA_COUNT  = 2,
   parameter int WORD_WIDTH = 16,
   parameter int LINE_WIDTH = 96,
   parameter int DEPTH      = 4
) (
   input  logic                             clk_in,
   input  logic                             rst_in,
   input  logic [FMA_COUNT*WORD_WIDTH-1:0]  fma_result_in,
   input  logic                             fma_valid_in,
   input  logic                             flush_in,
   input  logic                             mem_read_in,
   output logic                             fma_ready_out,
   output logic [LINE_WIDTH-1:0]            write_buffer_read_out,
   output logic                             write_buffer_valid_out,
   output logic [$clog2(DEPTH+1)-1:0]       count_out,
   output logic                             overflow_out
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

   logic [LINE_WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]         wr_ptr, rd_ptr, rd_next;
   logic [CW-1:0]         count, count_next;
   logic [LINE_WIDTH-1:0] pack, placed, line, head;
   logic [1:0]            slot;
   logic                  flush_pending, overflow;
   logic                  ready, accept, flush_req, commit_vec, commit_flush, push, pop;

   // FMA i's word lands at position i*3+slot, so slots become the a/b/c columns.
   always_comb begin
      placed = '0;
      for (int i = 0; i < FMA_COUNT; i++)
         placed[LINE_WIDTH-1-(i*3+int'(slot))*WORD_WIDTH -: WORD_WIDTH] =
            fma_result_in[(FMA_COUNT-i)*WORD_WIDTH-1 -: WORD_WIDTH];
   end

   always_comb begin
      ready        = (count != FULL) && !flush_pending;
      accept       = fma_valid_in && ready;
      flush_req    = flush_in && !accept && (slot != 2'd0);
      commit_vec   = accept && ((slot == 2'd2) || flush_in);
      commit_flush = (flush_pending || flush_req) && (count != FULL);
      push         = commit_vec || commit_flush;
      pop          = mem_read_in && (count != '0);
      line         = accept ? (pack | placed) : pack;
      rd_next      = rd_ptr;
      if (pop)
         rd_next = (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
      count_next = count;
      if (push && !pop)
         count_next = count + 1'b1;
      else if (!push && pop)
         count_next = count - 1'b1;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in && push)
         mem[wr_ptr] <= line;
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         count         <= '0;
         pack          <= '0;
         slot          <= 2'd0;
         flush_pending <= 1'b0;
         overflow      <= 1'b0;
         head          <= '0;
      end else begin
         if (push)
            wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
         rd_ptr <= rd_next;
         count  <= count_next;
         if (push) begin
            pack <= '0;
            slot <= 2'd0;
         end else if (accept) begin
            pack <= line;
            slot <= slot + 1'b1;
         end
         if (fma_valid_in && !ready)
            overflow <= 1'b1;
         if (commit_flush)
            flush_pending <= 1'b0;
         else if (flush_req)
            flush_pending <= 1'b1;
         // A line written this edge into the new head slot bypasses the array.
         if (count_next != '0)
            head <= (push && (wr_ptr == rd_next)) ? line : mem[rd_next];
      end
   end

   assign fma_ready_out          = ready;
   assign write_buffer_read_out  = head;
   assign write_buffer_valid_out = (count != '0);
   assign count_out              = count;
   assign overflow_out           = overflow;

endmodule

// File: tb/tb_fma_write_buffer.sv
// tb/tb_fma_write_buffer.sv - vector table, reset sequence and randomized run against a queue-based model
module tb_fma_write_buffer;

   localparam int FC = 2;
   localparam int W  = 16;
   localparam int LW = 96;
   localparam int DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [FC*W-1:0] res;
   logic          valid, flush, rd;
   logic          ready, wb_valid, ovf;
   logic [LW-1:0] wb_line;
   logic [2:0]    count;

   int total = 0;
   int bad   = 0;

   fma_write_buffer #(.FMA_COUNT(FC), .WORD_WIDTH(W), .LINE_WIDTH(LW), .DEPTH(DEPTH)) dut (
      .clk_in                (clk),
      .rst_in                (rst),
      .fma_result_in         (res),
      .fma_valid_in          (valid),
      .flush_in              (flush),
      .mem_read_in           (rd),
      .fma_ready_out         (ready),
      .write_buffer_read_out (wb_line),
      .write_buffer_valid_out(wb_valid),
      .count_out             (count),
      .overflow_out          (ovf)
   );

   always #5 clk = ~clk;

   // reference model: list of pending vectors and a queue of whole lines
   logic [FC*W-1:0] part[$];
   logic [LW-1:0]   mq[$];
   bit              m_pend, m_ovf;
   logic [LW-1:0]   m_head;

   function automatic logic [LW-1:0] build();
      logic [LW-1:0]   l;
      logic [FC*W-1:0] v;
      l = '0;
      for (int k = 0; k < part.size(); k++) begin
         v = part[k];
         for (int i = 0; i < FC; i++)
            l[LW-1-(i*3+k)*W -: W] = v[(FC-i)*W-1 -: W];
      end
      return l;
   endfunction

   task automatic model_reset();
      part.delete();
      mq.delete();
      m_pend = 0;
      m_ovf  = 0;
      m_head = '0;
   endtask

   task automatic model_step();
      int n;
      bit mready, do_push;
      logic [LW-1:0] l;
      n = mq.size();
      mready = (n != DEPTH) && !m_pend;
      do_push = 0;
      l = '0;
      if (valid && mready) begin
         part.push_back(res);
         if (part.size() == 3 || flush) begin
            l = build();
            part.delete();
            do_push = 1;
         end
      end else begin
         if (valid) m_ovf = 1;
         if (m_pend || (flush && part.size() > 0)) begin
            if (n < DEPTH) begin
               l = build();
               part.delete();
               do_push = 1;
               m_pend = 0;
            end else begin
               m_pend = 1;
            end
         end
      end
      if (rd && n > 0) void'(mq.pop_front());
      if (do_push) mq.push_back(l);
      if (mq.size() > 0) m_head = mq[0];
   endtask

   task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit v, input logic [FC*W-1:0] d, input bit f, input bit p);
      @(negedge clk);
      rst = r; valid = v; res = d; flush = f; rd = p;
      @(posedge clk);
      if (r) model_reset(); else model_step();
      #1;
   endtask

   task automatic chk_model(input string tag);
      chk({tag, ".count"}, count, mq.size());
      chk({tag, ".valid"}, wb_valid, mq.size() != 0);
      chk({tag, ".line"},  wb_line, m_head);
      chk({tag, ".ready"}, ready, (mq.size() != DEPTH) && !m_pend);
      chk({tag, ".ovf"},   ovf, m_ovf);
   endtask

   task automatic chk_exp(input string tag, input int c, input bit vl, input logic [LW-1:0] l,
                          input bit rdy, input bit o);
      chk({tag, ".count"}, count, c);
      chk({tag, ".valid"}, wb_valid, vl);
      chk({tag, ".line"},  wb_line, l);
      chk({tag, ".ready"}, ready, rdy);
      chk({tag, ".ovf"},   ovf, o);
   endtask

   typedef struct {
      bit            v;
      logic [31:0]   d;
      bit            f;
      bit            p;
      int            cnt;
      bit            val;
      logic [LW-1:0] line;
      bit            rdy;
      bit            o;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(bit v, logic [31:0] d, bit f, bit p, int cnt, bit val,
                               logic [LW-1:0] line, bit rdy, bit o);
      vec_t e;
      e.v = v; e.d = d; e.f = f; e.p = p; e.cnt = cnt; e.val = val;
      e.line = line; e.rdy = rdy; e.o = o;
      tbl.push_back(e);
   endfunction

   function automatic logic [LW-1:0] fill_line(int n);
      logic [15:0] a0, b0, c0, a1, b1, c1;
      a0 = 16'h0100 + 16'(3*n); b0 = a0 + 16'd1; c0 = a0 + 16'd2;
      a1 = 16'h0200 + 16'(3*n); b1 = a1 + 16'd1; c1 = a1 + 16'd2;
      return {a0, b0, c0, a1, b1, c1};
   endfunction

   initial begin
      logic [LW-1:0] l1, l2, g, f0;
      l1 = 96'h0001_0003_0005_0002_0004_0006;
      l2 = 96'h0007_0000_0000_0008_0000_0000;
      g  = 96'h0301_0303_0305_0302_0304_0306;
      f0 = fill_line(0);

      add(1, 32'h0001_0002, 0, 0, 0, 0, '0, 1, 0);
      add(1, 32'h0003_0004, 0, 0, 0, 0, '0, 1, 0);
      add(1, 32'h0005_0006, 0, 0, 1, 1, l1, 1, 0);
      add(1, 32'h0007_0008, 1, 0, 2, 1, l1, 1, 0);
      add(0, 32'h0,         1, 0, 2, 1, l1, 1, 0);
      add(0, 32'h0,         0, 1, 1, 1, l2, 1, 0);
      add(0, 32'h0,         0, 1, 0, 0, l2, 1, 0);
      add(0, 32'h0,         0, 1, 0, 0, l2, 1, 0);
      for (int j = 0; j < 12; j++)
         add(1, {16'h0100 + 16'(j), 16'h0200 + 16'(j)}, 0, 0, (j+1)/3, j >= 2,
             (j >= 2) ? f0 : l2, ((j+1)/3) != DEPTH, 0);
      add(1, 32'h0aaa_0bbb, 0, 0, 4, 1, f0, 0, 1);
      add(0, 32'h0,         0, 0, 4, 1, f0, 0, 1);
      add(0, 32'h0,         0, 1, 3, 1, fill_line(1), 1, 1);
      add(0, 32'h0,         0, 1, 2, 1, fill_line(2), 1, 1);
      add(1, 32'h0301_0302, 0, 0, 2, 1, fill_line(2), 1, 1);
      add(1, 32'h0303_0304, 0, 0, 2, 1, fill_line(2), 1, 1);
      add(1, 32'h0305_0306, 0, 1, 2, 1, fill_line(3), 1, 1);
      add(0, 32'h0,         0, 1, 1, 1, g, 1, 1);
      add(0, 32'h0,         0, 1, 0, 0, g, 1, 1);

      model_reset();
      step(1, 0, '0, 0, 0);
      step(1, 0, '0, 0, 0);
      step(0, 0, '0, 0, 0);
      chk_exp("reset", 0, 0, '0, 1, 0);

      for (int t = 0; t < tbl.size(); t++) begin
         step(0, tbl[t].v, tbl[t].d, tbl[t].f, tbl[t].p);
         chk_exp($sformatf("tbl%0d", t), tbl[t].cnt, tbl[t].val, tbl[t].line, tbl[t].rdy, tbl[t].o);
      end

      // reset with two lines queued and one vector partially packed
      step(1, 0, '0, 0, 0);
      for (int j = 0; j < 7; j++)
         step(0, 1, {16'h0900 + 16'(j), 16'h0a00 + 16'(j)}, 0, 0);
      chk("pre_rst.count", count, 2);
      step(1, 1, 32'h1111_2222, 0, 1);
      chk_exp("mid_rst", 0, 0, '0, 1, 0);
      step(0, 1, 32'h0011_0012, 0, 0);
      step(0, 1, 32'h0013_0014, 0, 0);
      step(0, 1, 32'h0015_0016, 0, 0);
      chk_exp("post_rst", 1, 1, 96'h0011_0013_0015_0012_0014_0016, 1, 0);

      step(1, 0, '0, 0, 0);
      for (int c = 0; c < 800; c++) begin
         int rdp;
         rdp = (c < 400) ? 20 : 60;
         step(0, $urandom_range(0, 99) < 65, $urandom, $urandom_range(0, 99) < 12,
              $urandom_range(0, 99) < rdp);
         chk_model($sformatf("rnd%0d", c));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
